// File: rtl/led_p2s_pkg.sv
// Shared types and constants for the LED serial back end (led_p2s_engine).
package led_p2s_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_CLEAR    = 3'd1,
      ST_SHIFT_LO = 3'd2,
      ST_SHIFT_HI = 3'd3,
      ST_LATCH    = 3'd4
   } led_p2s_state_e;

   localparam int unsigned DIR_MSB_FIRST = 0;
   localparam int unsigned DIR_LSB_FIRST = 1;

endpackage

// File: rtl/led_p2s_tick.sv
// Phase divider: one-cycle tick every CLK_DIV clocks, restarted by a synchronous clear.
module led_p2s_tick #(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic clk,
   input  logic rstn,
   input  logic clr,
   output logic tick
);

   localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      tick  = (cnt_q == LAST);
      cnt_d = cnt_q + 1'b1;
      if (clr || tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/led_p2s_engine.sv
// Parallel-to-serial driver for an external shift-register LED chain.
// Optional chain-clear phase before each frame: define LED_P2S_CLEAR_EN.
module led_p2s_engine
   import led_p2s_pkg::*;
#(
   parameter int unsigned DATA_BITS       = 16,
   parameter int unsigned DATA_COUNT_BITS = 4,
   parameter int unsigned DIR             = 0,
   parameter int unsigned CLK_DIV         = 2
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 start,
   input  logic [DATA_BITS-1:0] pdata,
   output logic                 sclk,
   output logic                 sout,
   output logic                 sclrn,
   output logic                 sen,
   output logic                 busy,
   output logic                 done
);

   localparam logic [DATA_COUNT_BITS-1:0] LAST_BIT = DATA_COUNT_BITS'(DATA_BITS - 1);

   led_p2s_state_e             state_q, state_d;
   logic [DATA_BITS-1:0]       shreg_q, shreg_d;
   logic [DATA_COUNT_BITS-1:0] bitcnt_q, bitcnt_d;
   logic sclk_q, sclk_d, sout_q, sout_d, sen_q, sen_d;
   logic busy_q, busy_d, done_q, done_d;
   logic sclrn_q, sclrn_d;
   logic accept, div_clr, tick;

   led_p2s_tick #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk  (clk),
      .rstn (rstn),
      .clr  (div_clr),
      .tick (tick)
   );

   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      bitcnt_d = bitcnt_q;
      done_d   = 1'b0;
      accept   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) accept = 1'b1;
         end
`ifdef LED_P2S_CLEAR_EN
         ST_CLEAR: begin
            if (tick) state_d = ST_SHIFT_LO;
         end
`endif
         ST_SHIFT_LO: begin
            if (tick) state_d = ST_SHIFT_HI;
         end
         ST_SHIFT_HI: begin
            if (tick) begin
               if (bitcnt_q == LAST_BIT) begin
                  state_d = ST_LATCH;
               end else begin
                  shreg_d  = (DIR == DIR_LSB_FIRST) ? (shreg_q >> 1) : (shreg_q << 1);
                  bitcnt_d = bitcnt_q + 1'b1;
                  state_d  = ST_SHIFT_LO;
               end
            end
         end
         ST_LATCH: begin
            // A start seen on the final latch cycle chains the next frame with no idle gap.
            if (tick) begin
               done_d = 1'b1;
               if (start) accept = 1'b1;
               else       state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      div_clr = accept;
      if (accept) begin
         shreg_d  = pdata;
         bitcnt_d = '0;
`ifdef LED_P2S_CLEAR_EN
         state_d  = ST_CLEAR;
`else
         state_d  = ST_SHIFT_LO;
`endif
      end

      sclk_d  = (state_d == ST_SHIFT_HI);
      sen_d   = (state_d == ST_LATCH);
      sclrn_d = (state_d != ST_CLEAR);
      busy_d  = (state_d != ST_IDLE);
      if (state_d inside {ST_CLEAR, ST_SHIFT_LO, ST_SHIFT_HI}) begin
         sout_d = (DIR == DIR_MSB_FIRST) ? shreg_d[DATA_BITS-1] : shreg_d[0];
      end else begin
         sout_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= ST_IDLE;
         shreg_q  <= '0;
         bitcnt_q <= '0;
         sclk_q   <= 1'b0;
         sout_q   <= 1'b0;
         sclrn_q  <= 1'b1;
         sen_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         bitcnt_q <= bitcnt_d;
         sclk_q   <= sclk_d;
         sout_q   <= sout_d;
         sclrn_q  <= sclrn_d;
         sen_q    <= sen_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign sclk = sclk_q;
   assign sout = sout_q;
   assign sen  = sen_q;
   assign busy = busy_q;
   assign done = done_q;
`ifdef LED_P2S_CLEAR_EN
   assign sclrn = sclrn_q;
`else
   assign sclrn = 1'b1;
`endif

endmodule

// File: tb/tb_led_p2s_engine.sv
// Self-checking bench for led_p2s_engine (three configurations, honours LED_P2S_CLEAR_EN).
module tb_led_p2s_engine;

`ifdef LED_P2S_CLEAR_EN
   localparam int CLR_EXTRA = 1;
`else
   localparam int CLR_EXTRA = 0;
`endif

   logic        clk = 1'b0;
   logic        rstn;
   logic [2:0]  start_v;
   logic [15:0] pd0, pd1;
   logic [7:0]  pd2;
   logic [2:0]  sclk_v, sout_v, sclrn_v, sen_v, busy_v, done_v;

   int checks   = 0;
   int failures = 0;

   int db_c [3] = '{16, 16, 8};
   int div_c[3] = '{2, 2, 1};
   int dir_c[3] = '{0, 1, 0};

   // capture results
   int          cap_len, cap_sen, cap_done, cap_clr, cap_bad, cap_n;
   logic [31:0] cap_v;

   always #5 clk = ~clk;

   led_p2s_engine u_dut0 (
      .clk(clk), .rstn(rstn), .start(start_v[0]), .pdata(pd0),
      .sclk(sclk_v[0]), .sout(sout_v[0]), .sclrn(sclrn_v[0]), .sen(sen_v[0]),
      .busy(busy_v[0]), .done(done_v[0]));

   led_p2s_engine #(.DIR(1)) u_dut1 (
      .clk(clk), .rstn(rstn), .start(start_v[1]), .pdata(pd1),
      .sclk(sclk_v[1]), .sout(sout_v[1]), .sclrn(sclrn_v[1]), .sen(sen_v[1]),
      .busy(busy_v[1]), .done(done_v[1]));

   led_p2s_engine #(.DATA_BITS(8), .DATA_COUNT_BITS(3), .CLK_DIV(1)) u_dut2 (
      .clk(clk), .rstn(rstn), .start(start_v[2]), .pdata(pd2),
      .sclk(sclk_v[2]), .sout(sout_v[2]), .sclrn(sclrn_v[2]), .sen(sen_v[2]),
      .busy(busy_v[2]), .done(done_v[2]));

   // Serial stream as seen by the chain, first bit ending up leftmost.
   function automatic logic [31:0] exp_vec(input logic [15:0] data, input int nb, input int dir);
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < nb; i++) v = {v[30:0], (dir != 0) ? data[i] : data[nb-1-i]};
      return v;
   endfunction

   function automatic int frame_len(input int nb, input int div);
      return 2 * div * nb + div + CLR_EXTRA * div;
   endfunction

   task automatic launch(input int d, input logic [15:0] data);
      @(negedge clk);
      start_v[d] = 1'b1;
      case (d)
         0: pd0 = data;
         1: pd1 = data;
         default: pd2 = data[7:0];
      endcase
      @(posedge clk);
      #1 start_v[d] = 1'b0;
   endtask

   // Samples cycle e after the accepting edge; stops on done or budget.
   task automatic capture(input int d, input int budget);
      logic prev;
      prev = 1'b0;
      cap_len = 0; cap_sen = 0; cap_clr = 0; cap_bad = 0; cap_n = 0;
      cap_done = -1; cap_v = '0;
      for (int e = 0; e < budget; e++) begin
         @(negedge clk);
         if (busy_v[d]) cap_len++;
         if (sen_v[d]) cap_sen++;
         if (!sclrn_v[d]) begin
            cap_clr++;
            if (sclk_v[d]) cap_bad++;
         end
         if (sclk_v[d] && !prev) begin
            cap_v = {cap_v[30:0], sout_v[d]};
            cap_n++;
         end
         prev = sclk_v[d];
         if (done_v[d]) begin
            cap_done = e;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rstn = 1'b0; start_v = '0; pd0 = '0; pd1 = '0; pd2 = '0;
      #3;
      for (int d = 0; d < 3; d++) begin
         checks++;
         if ({sclk_v[d], sout_v[d], sclrn_v[d], sen_v[d], busy_v[d], done_v[d]} !== 6'b001000) begin
            failures++;
            $display("FAIL reset_async dut%0d: got %b expected 001000", d,
                     {sclk_v[d], sout_v[d], sclrn_v[d], sen_v[d], busy_v[d], done_v[d]});
         end
      end
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      repeat (2) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         checks++;
         if ({sclk_v[d], sout_v[d], sclrn_v[d], sen_v[d], busy_v[d], done_v[d]} !== 6'b001000) begin
            failures++;
            $display("FAIL idle_after_reset dut%0d: got %b expected 001000", d,
                     {sclk_v[d], sout_v[d], sclrn_v[d], sen_v[d], busy_v[d], done_v[d]});
         end
      end
   endtask

   task automatic test_msb_first;
      logic [15:0] data;
      int          len;
      len = frame_len(16, 2);
      for (int t = 0; t < 4; t++) begin
         data = (t == 0) ? 16'hA55A : 16'($urandom);
         launch(0, data);
         capture(0, len + 20);
         checks++;
         if (cap_v !== exp_vec(data, 16, 0) || cap_n != 16) begin
            failures++;
            $display("FAIL msb_bits pdata=%h: got %h/%0d bits expected %h/16", data, cap_v, cap_n, exp_vec(data, 16, 0));
         end
         if (t == 0) begin
            checks++;
            if (cap_v[15:0] !== 16'b1010010101011010) begin
               failures++;
               $display("FAIL msb_a55a_pattern: got %b expected 1010010101011010", cap_v[15:0]);
            end
         end
         checks++;
         if (cap_done != len || cap_len != len) begin
            failures++;
            $display("FAIL msb_timing: done_at=%0d busy=%0d expected %0d/%0d", cap_done, cap_len, len, len);
         end
         checks++;
         if (cap_sen != 2 || cap_clr != 2 * CLR_EXTRA || cap_bad != 0) begin
            failures++;
            $display("FAIL msb_sen_clr: sen=%0d clr=%0d sclk_in_clr=%0d expected 2/%0d/0", cap_sen, cap_clr, cap_bad, 2 * CLR_EXTRA);
         end
      end
   endtask

   task automatic test_lsb_first;
      logic [15:0] data;
      int          len;
      len = frame_len(16, 2);
      for (int t = 0; t < 3; t++) begin
         data = (t == 0) ? 16'h0001 : 16'($urandom);
         launch(1, data);
         capture(1, len + 20);
         checks++;
         if (cap_v !== exp_vec(data, 16, 1) || cap_n != 16) begin
            failures++;
            $display("FAIL lsb_bits pdata=%h: got %h/%0d bits expected %h/16", data, cap_v, cap_n, exp_vec(data, 16, 1));
         end
         if (t == 0) begin
            checks++;
            if (cap_v[15:0] !== 16'h8000) begin
               failures++;
               $display("FAIL lsb_0001_pattern: got %b expected 1000000000000000", cap_v[15:0]);
            end
         end
         checks++;
         if (cap_done != len || cap_sen != 2) begin
            failures++;
            $display("FAIL lsb_timing: done_at=%0d sen=%0d expected %0d/2", cap_done, cap_sen, len);
         end
      end
   endtask

   task automatic test_div1_short;
      logic [15:0] data;
      int          len;
      len = frame_len(8, 1);
      for (int t = 0; t < 3; t++) begin
         data = (t == 0) ? 16'h00C3 : {8'h00, 8'($urandom)};
         launch(2, data);
         capture(2, len + 20);
         checks++;
         if (cap_v !== exp_vec(data, 8, 0) || cap_n != 8) begin
            failures++;
            $display("FAIL div1_bits pdata=%h: got %h/%0d bits expected %h/8", data[7:0], cap_v, cap_n, exp_vec(data, 8, 0));
         end
         checks++;
         if (cap_done != len || cap_len != len || cap_sen != 1 || cap_clr != CLR_EXTRA) begin
            failures++;
            $display("FAIL div1_timing: done_at=%0d busy=%0d sen=%0d clr=%0d expected %0d/%0d/1/%0d",
                     cap_done, cap_len, cap_sen, cap_clr, len, len, CLR_EXTRA);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [15:0] p[3];
      int          dones[$];
      int          len, gap, n, fidx;
      logic [31:0] v;
      logic        prev;
      len = frame_len(16, 2);
      for (int i = 0; i < 3; i++) p[i] = 16'($urandom);
      gap = 0; n = 0; v = '0; prev = 1'b0; fidx = 0;
      @(negedge clk);
      start_v[0] = 1'b1;
      pd0 = p[0];
      @(posedge clk);
      for (int e = 0; e < 3 * len + 20; e++) begin
         @(negedge clk);
         if (e == 20)           pd0 = p[1];
         if (e == len + 20)     pd0 = p[2];
         if (e == 2 * len + 20) start_v[0] = 1'b0;
         if (!busy_v[0] && e < 3 * len) gap++;
         if (sclk_v[0] && !prev) begin
            v = {v[30:0], sout_v[0]};
            n++;
         end
         prev = sclk_v[0];
         if (done_v[0]) begin
            dones.push_back(e);
            checks++;
            if (v !== exp_vec(p[fidx], 16, 0) || n != 16) begin
               failures++;
               $display("FAIL b2b_frame%0d_bits: got %h/%0d bits expected %h/16", fidx, v, n, exp_vec(p[fidx], 16, 0));
            end
            v = '0; n = 0; fidx++;
            if (fidx == 3) break;
         end
      end
      start_v[0] = 1'b0;
      checks++;
      if (dones.size() != 3 || dones[0] != len || dones[1] != 2 * len || dones[2] != 3 * len) begin
         failures++;
         $display("FAIL b2b_done_spacing: got %0d pulses first=%0d expected 3 at %0d,%0d,%0d",
                  dones.size(), (dones.size() > 0) ? dones[0] : -1, len, 2 * len, 3 * len);
      end
      checks++;
      if (gap != 0 || busy_v[0] !== 1'b0) begin
         failures++;
         $display("FAIL b2b_busy: idle_cycles=%0d busy_at_end=%b expected 0/0", gap, busy_v[0]);
      end
   endtask

   task automatic test_reset_midframe;
      int rises, busy_cnt, len;
      logic prev;
      len = frame_len(16, 2);
      launch(0, 16'hFFFF);
      repeat (20) @(negedge clk);
      checks++;
      if (busy_v[0] !== 1'b1 || sout_v[0] !== 1'b1) begin
         failures++;
         $display("FAIL midframe_pre: busy=%b sout=%b expected 1/1", busy_v[0], sout_v[0]);
      end
      #1 rstn = 1'b0;
      #1;
      checks++;
      if ({sclk_v[0], sout_v[0], sclrn_v[0], sen_v[0], busy_v[0], done_v[0]} !== 6'b001000) begin
         failures++;
         $display("FAIL midframe_async_reset: got %b expected 001000",
                  {sclk_v[0], sout_v[0], sclrn_v[0], sen_v[0], busy_v[0], done_v[0]});
      end
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      rises = 0; busy_cnt = 0; prev = 1'b0;
      for (int e = 0; e < 2 * len; e++) begin
         @(negedge clk);
         if (sclk_v[0] && !prev) rises++;
         if (busy_v[0]) busy_cnt++;
         prev = sclk_v[0];
      end
      checks++;
      if (rises != 0 || busy_cnt != 0) begin
         failures++;
         $display("FAIL post_reset_quiet: sclk_rises=%0d busy_cycles=%0d expected 0/0", rises, busy_cnt);
      end
      launch(0, 16'h3C96);
      capture(0, len + 20);
      checks++;
      if (cap_v !== exp_vec(16'h3C96, 16, 0) || cap_done != len) begin
         failures++;
         $display("FAIL post_reset_frame: got %h done_at=%0d expected %h/%0d", cap_v, cap_done, exp_vec(16'h3C96, 16, 0), len);
      end
   endtask

   initial begin
      test_reset();
      test_msb_first();
      test_lsb_first();
      test_div1_short();
      test_back_to_back();
      repeat (4) @(negedge clk);
      test_reset_midframe();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
